serial_paralelo_rx: RTL and testbench
=====================================

SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 Parameter COM, default 8'hBC: comma/idle symbol used for alignment and for idle filler.
REQ-002 Parameter SYNC_COUNT, default 4: number of consecutive aligned COM bytes required to declare link active.
REQ-003 clk_32f  input  1  the only clock; all logic samples on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-005 data_in  input  1  serial bit stream, MSB of each byte first, one bit per clk_32f cycle.
REQ-006 dataOut  output  8  last received non-COM byte, registered.
REQ-007 validOut  output  1  1 = dataOut carries a data byte received at the current byte boundary.
REQ-008 byte_stb  output  1  one-cycle pulse at every aligned byte boundary, in the COUNT and ACTIVE states only.
REQ-009 active  output  1  1 = receiver aligned and synchronized (state ACTIVE).

Function
REQ-010 Every cycle, an 8-bit shift register shall load {sr[6:0], data_in}; nxt denotes this value.
REQ-011 A 3-bit counter bit_cnt shall mark byte boundaries; the boundary is the edge where bit_cnt==7, and bit_cnt wraps 7->0.
REQ-012 The FSM shall have the states SEARCH, COUNT and ACTIVE.
REQ-013 In SEARCH, nxt is checked at every edge regardless of bit_cnt; when nxt==COM, the block shall set bit_cnt=0 (next 8 bits form the next byte), com_cnt=1 and go to COUNT.
REQ-014 In COUNT, at a boundary with nxt==COM: com_cnt increments; when the incremented value equals SYNC_COUNT, go to ACTIVE and clear com_cnt.
REQ-015 In COUNT, at a boundary with nxt!=COM: clear com_cnt and return to SEARCH; no valid is asserted.
REQ-016 In ACTIVE, at a boundary with nxt!=COM: dataOut=nxt and validOut=1.
REQ-017 In ACTIVE, at a boundary with nxt==COM: validOut=0 and dataOut holds its value.
REQ-018 ACTIVE is left only by reset.
REQ-019 validOut shall change only at boundaries; it holds its value between boundaries.
REQ-020 byte_stb shall be 1 only in the cycle after a boundary edge in COUNT or ACTIVE.
REQ-021 active shall be registered; it goes to 1 at the same edge as the SEARCH/COUNT->ACTIVE transition.
REQ-022 Latency: dataOut/validOut update at the edge that samples a byte's 8th bit, and are visible one cycle after that bit is presented.
REQ-023 The boundary edge that completes the SYNC_COUNT-th COM shall not assert validOut; the first data byte can appear on the next boundary (8 cycles later).
REQ-024 com_cnt shall saturate at SYNC_COUNT, so no width overflow is possible for SYNC_COUNT up to 15.

Reset
REQ-025 While reset==0: state=SEARCH, sr=0, bit_cnt=0, com_cnt=0, dataOut=8'h00, validOut=0, byte_stb=0, active=0.
REQ-026 Deasserting reset mid-byte shall restart alignment from SEARCH; no partial byte shall ever be output.
REQ-027 Reset shall be asynchronous on assertion; the first functional edge is the first clk_32f rising edge with reset==1.

Verification
REQ-028 Reset held, then released; stream 4x BC then 0x55 -> active=1 after the 4th BC boundary; next boundary gives dataOut=0x55, validOut=1.
REQ-029 Three garbage bits (1,0,1), then 4x BC, then 0xA3 -> alignment is on the BC byte boundary; dataOut=0xA3, validOut=1; no spurious validOut earlier.
REQ-030 3x BC, 0x12, 4x BC, 0x34 -> return to SEARCH at 0x12 with active=0 and no valid; active=1 after the later 4x BC; dataOut=0x34.
REQ-031 ACTIVE with stream 0x01, BC, 0x02 -> validOut 1,0,1 on consecutive boundaries; dataOut 0x01, 0x01, 0x02; byte_stb pulses every 8 cycles.
REQ-032 reset driven low at bit 4 of a data byte while ACTIVE -> all outputs immediately at reset values; after release, 4x BC again needed before any validOut.

Source files
------------

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver with comma alignment.
// Hunts for the COM symbol bit by bit, then requires SYNC_COUNT aligned
// COM bytes before declaring the link active. Once active, every non-COM
// byte is presented on dataOut with a validOut flag. COM bytes act as idle
// filler and clear validOut.
module serial_paralelo_rx #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] dataOut,
    output logic       validOut,
    output logic       byte_stb,
    output logic       active
);

    localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

    typedef enum logic [1:0] {
        SEARCH,
        COUNT,
        ACTIVE
    } RxState;

    RxState     state;
    RxState     stateNext;
    logic [7:0] shiftReg;
    logic [7:0] nxt;
    logic [2:0] bitCnt;
    logic [2:0] bitCntNext;
    logic [3:0] comCnt;
    logic [3:0] comCntNext;
    logic [3:0] comInc;
    logic       boundary;
    logic [7:0] dataNext;
    logic       validNext;
    logic       stbNext;
    logic       activeNext;

    // Register every piece of receiver state; reset restarts the alignment hunt.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state    <= SEARCH;
            shiftReg <= 8'h00;
            bitCnt   <= 3'd0;
            comCnt   <= 4'd0;
            dataOut  <= 8'h00;
            validOut <= 1'b0;
            byte_stb <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= stateNext;
            shiftReg <= nxt;
            bitCnt   <= bitCntNext;
            comCnt   <= comCntNext;
            dataOut  <= dataNext;
            validOut <= validNext;
            byte_stb <= stbNext;
            active   <= activeNext;
        end
    end

    // Decide alignment, COM counting and data capture from the byte that the
    // current edge completes (nxt already includes the incoming bit).
    always_comb begin
        nxt        = {shiftReg[6:0], data_in};
        boundary   = (bitCnt == 3'd7);
        comInc     = (comCnt >= SYNC_TARGET) ? comCnt : comCnt + 4'd1;
        stateNext  = state;
        bitCntNext = bitCnt + 3'd1;
        comCntNext = comCnt;
        dataNext   = dataOut;
        validNext  = validOut;
        stbNext    = boundary && (state != SEARCH);
        activeNext = active;

        case (state)
            SEARCH: begin
                if (nxt == COM) begin
                    bitCntNext = 3'd0;
                    if (SYNC_TARGET <= 4'd1) begin
                        stateNext  = ACTIVE;
                        comCntNext = 4'd0;
                        activeNext = 1'b1;
                    end else begin
                        stateNext  = COUNT;
                        comCntNext = 4'd1;
                    end
                end
            end
            COUNT: begin
                if (boundary) begin
                    if (nxt == COM) begin
                        if (comInc == SYNC_TARGET) begin
                            stateNext  = ACTIVE;
                            comCntNext = 4'd0;
                            activeNext = 1'b1;
                        end else begin
                            comCntNext = comInc;
                        end
                    end else begin
                        stateNext  = SEARCH;
                        comCntNext = 4'd0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    validNext = (nxt != COM);
                    if (nxt != COM) begin
                        dataNext = nxt;
                    end
                end
            end
            default: begin
                stateNext = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Testbench for serial_paralelo_rx: directed scenarios plus random streams,
// each checked cycle by cycle against a stream-parsing reference model.
module tb_serial_paralelo_rx;

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam int         SYNC    = 4;
    localparam int         MAXC    = 1024;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] dataOut;
    logic       validOut;
    logic       byte_stb;
    logic       active;

    int checks;
    int failures;

    bit         streamQ[$];
    logic [7:0] expData[0:MAXC-1];
    bit         expValid[0:MAXC-1];
    bit         expStb[0:MAXC-1];
    bit         expActive[0:MAXC-1];

    serial_paralelo_rx #(
        .COM(COM_SYM),
        .SYNC_COUNT(SYNC)
    ) dut (
        .clk_32f(clk_32f),
        .reset(reset),
        .data_in(data_in),
        .dataOut(dataOut),
        .validOut(validOut),
        .byte_stb(byte_stb),
        .active(active)
    );

    // Free-running receive clock.
    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".dataOut"}, {24'd0, dataOut}, 32'h0);
        checkOutput({tag, ".validOut"}, {31'd0, validOut}, 32'h0);
        checkOutput({tag, ".byte_stb"}, {31'd0, byte_stb}, 32'h0);
        checkOutput({tag, ".active"}, {31'd0, active}, 32'h0);
    endtask

    task automatic addByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) streamQ.push_back(b[i]);
    endtask

    task automatic addComs(input int n);
        for (int i = 0; i < n; i++) addByte(COM_SYM);
    endtask

    // Last eight received bits ending at bit k, with zeros before the stream start.
    function automatic logic [7:0] windowAt(input int k);
        logic [7:0] w;
        w = 8'h00;
        for (int j = 7; j >= 0; j--) begin
            if (k - j >= 0) w = {w[6:0], 1'(streamQ[k - j])};
            else            w = {w[6:0], 1'b0};
        end
        return w;
    endfunction

    // Parse the whole stream: find the first comma, walk byte boundaries from
    // there, count commas until the link is up, then report data bytes.
    function automatic void buildExpected(input int n);
        logic [7:0] data;
        logic [7:0] w;
        bit         valid;
        bit         act;
        bit         aligned;
        bit         stb;
        int         comRun;
        int         nextBoundary;
        data = 8'h00; valid = 0; act = 0; aligned = 0; comRun = 0; nextBoundary = -1;
        for (int k = 0; k < n; k++) begin
            w   = windowAt(k);
            stb = 0;
            if (!aligned) begin
                if (w == COM_SYM) begin
                    aligned      = 1;
                    nextBoundary = k + 8;
                    comRun       = 1;
                    if (comRun >= SYNC) act = 1;
                end
            end else if (k == nextBoundary) begin
                stb          = 1;
                nextBoundary = k + 8;
                if (act) begin
                    valid = (w != COM_SYM);
                    if (valid) data = w;
                end else if (w == COM_SYM) begin
                    comRun++;
                    if (comRun == SYNC) act = 1;
                end else begin
                    aligned = 0;
                    comRun  = 0;
                end
            end
            expData[k]   = data;
            expValid[k]  = valid;
            expStb[k]    = stb;
            expActive[k] = act;
        end
    endfunction

    // Drive bits [0, stopAt) of the queued stream, one per clock, checking every cycle.
    task automatic applyStimulus(input string name, input int stopAt);
        buildExpected(streamQ.size());
        for (int k = 0; k < stopAt; k++) begin
            data_in = streamQ[k];
            @(posedge clk_32f);
            #1;
            checkOutput($sformatf("%s.b%0d.dataOut", name, k), {24'd0, dataOut}, {24'd0, expData[k]});
            checkOutput($sformatf("%s.b%0d.validOut", name, k), {31'd0, validOut}, {31'd0, expValid[k]});
            checkOutput($sformatf("%s.b%0d.byte_stb", name, k), {31'd0, byte_stb}, {31'd0, expStb[k]});
            checkOutput($sformatf("%s.b%0d.active", name, k), {31'd0, active}, {31'd0, expActive[k]});
        end
    endtask

    // Assert reset between clock edges, confirm outputs cleared at once, release on a falling edge.
    task automatic applyReset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        checkResetState(tag);
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b1;
        streamQ.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        data_in  = 1'b0;
        streamQ.delete();

        // Held reset ignores input activity.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_32f);
            data_in = i[0];
        end
        #1;
        checkResetState("resetHeld");
        @(negedge clk_32f);
        reset = 1'b1;

        // Four commas then 0x55, trailing comma keeps the data but drops valid.
        addComs(4); addByte(8'h55); addByte(COM_SYM);
        applyStimulus("basic", streamQ.size());
        checkOutput("basic.endData", {24'd0, dataOut}, 32'h55);
        checkOutput("basic.endValid", {31'd0, validOut}, 32'h0);
        checkOutput("basic.endActive", {31'd0, active}, 32'h1);

        // Garbage bits before the commas.
        applyReset("rst1");
        streamQ.push_back(1); streamQ.push_back(0); streamQ.push_back(1);
        addComs(4); addByte(8'hA3);
        applyStimulus("garbage", streamQ.size());
        checkOutput("garbage.endData", {24'd0, dataOut}, 32'hA3);
        checkOutput("garbage.endValid", {31'd0, validOut}, 32'h1);

        // Broken comma run falls back to search.
        applyReset("rst2");
        addComs(3); addByte(8'h12); addComs(4); addByte(8'h34);
        applyStimulus("broken", streamQ.size());
        checkOutput("broken.endData", {24'd0, dataOut}, 32'h34);
        checkOutput("broken.endValid", {31'd0, validOut}, 32'h1);

        // Data, idle comma, data.
        applyReset("rst3");
        addComs(4); addByte(8'h01); addByte(COM_SYM); addByte(8'h02);
        applyStimulus("idle", streamQ.size());
        checkOutput("idle.endData", {24'd0, dataOut}, 32'h02);

        // Reset in the middle of a data byte while active.
        applyReset("rst4");
        addComs(4); addByte(8'h5A); addByte(8'h77);
        applyStimulus("midByte", streamQ.size() - 4);
        checkOutput("midByte.activeBefore", {31'd0, active}, 32'h1);
        applyReset("rstMid");
        addByte(8'h66); addComs(3); addByte(8'h11); addComs(4); addByte(8'h22);
        applyStimulus("afterMid", streamQ.size());
        checkOutput("afterMid.endData", {24'd0, dataOut}, 32'h22);

        // Random streams with random comma run lengths and idle commas.
        for (int s = 0; s < 6; s++) begin
            int garbage;
            int runLen;
            applyReset($sformatf("rstRand%0d", s));
            garbage = $urandom_range(0, 10);
            runLen  = $urandom_range(2, 5);
            for (int i = 0; i < garbage; i++) streamQ.push_back(1'($urandom));
            addComs(runLen);
            for (int i = 0; i < 24; i++) begin
                if ($urandom_range(0, 3) == 0) addByte(COM_SYM);
                else                           addByte(8'($urandom));
            end
            applyStimulus($sformatf("rand%0d", s), streamQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
